regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (enable, RW, PW) among NREQ writeback requesters, e.g. ALU, load unit, multiply unit and link write.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Arbitration among pending buffers is round-robin; writes to R0 are discarded.
- Exports a pending-write scoreboard so the issue stage can stall on register hazards.

Parameters:
- NREQ, 4, number of writeback requesters (2..8).
- CW, 16, width of the committed-write counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  requester i presents a write.
- req_ready  out  NREQ  requester i's write is accepted at this edge when valid is also high.
- req_rd  in  5*NREQ  destination register; slice i = [5i+4:5i].
- req_data  in  32*NREQ  write data; slice i = [32i+31:32i].
- rf_enable  out  1  drives the register-file write enable.
- rf_RW  out  5  drives the register-file write address.
- rf_PW  out  32  drives the register-file write data.
- pending  out  32  bit r = a write to register r is buffered or on rf_*.
- grant_id  out  $clog2(NREQ)  requester whose write is currently on rf_*.
- commit_count  out  CW  number of rf_enable cycles since reset; wraps.

Behaviour:
- Reset (reset_n=0 at an edge):
  - All buffers empty; rr_ptr=0.
  - rf_enable=0, rf_RW=0, rf_PW=0, grant_id=0, commit_count=0.
  - pending=0.
  - req_ready=0 combinationally while reset_n=0.
  - Reset mid-operation discards all buffered writes, and any write on rf_* is not performed.
- Acceptance at an edge, for requester i, when req_valid[i] & req_ready[i]:
  - If req_rd[i]==0: the write is dropped. The buffer stays empty and there is no rf_* activity.
  - Otherwise: buf[i] <= {rd, data}; buf[i] becomes valid.
- req_ready[i] is combinational. It is 1 only when all of the following hold:
  - reset_n=1;
  - buf[i] is empty, or buf[i] is granted this cycle;
  - req_rd[i] (if nonzero) matches no valid buf[j] with j!=i that is not granted this cycle;
  - req_rd[i] matches no req_rd[j] with j<i for which req_valid[j] & req_ready[j] this cycle.
- Consequences of the ready rule:
  - At most one buffered write per register exists at any time.
  - Writes to the same register commit in acceptance order. On simultaneous requests, the lower index goes first.
  - req_ready never depends on req_valid[i] itself.
- Arbitration (combinational, each cycle):
  - Scan buffers starting at rr_ptr, modulo NREQ. The first valid buffer g is granted.
  - At the edge: rf_enable<=1, rf_RW<=buf[g].rd, rf_PW<=buf[g].data, grant_id<=g, rr_ptr<=(g+1) mod NREQ.
  - buf[g] is cleared unless it is reloaded at the same edge.
  - No valid buffer: rf_enable<=0; rf_RW, rf_PW, grant_id and rr_ptr hold.
- Output registers:
  - rf_* are registered, so the register file writes at the edge after grant.
  - Minimum latency: accepted at edge k, rf_enable=1 after edge k+1, register written at edge k+2.
  - Throughput is one write per cycle.
- Granted requester refill: a requester granted in a cycle may be accepted again at the same edge, which gives back-to-back throughput for a single requester.
- commit_count: increments at each edge where rf_enable==1, wrapping at 2^CW.
- pending[r] = (any valid buf with rd==r) | (rf_enable & rf_RW==r). pending[0] is always 0. pending is combinational from state only.
- Fairness: with all NREQ buffers continuously refilled, each requester is granted exactly once every NREQ cycles.

Test Plan:
- Reset → all outputs listed above are 0; req_ready=0 during reset. Then single req0 {rd=5, data=0xDEADBEEF} → rf_enable=1, rf_RW=5, rf_PW=0xDEADBEEF two edges after acceptance; pending[5] is high for those two cycles; commit_count=1.
- All 4 requesters valid every cycle with distinct rd 1..4 → grant_id sequence 0,1,2,3,0,1,…; one rf_enable per cycle; no requester waits more than 4 cycles.
- req1 and req3 both valid with rd=7, buffers empty → only req_ready[1]=1. req3 is accepted only after buf1 is granted, and rf_PW order is data1 then data3.
- req2 rd=0 data=0x12345678 → accepted (ready=1); rf_enable stays 0; pending=0; commit_count unchanged.
- buf0 holding rd=9 and req2 offering rd=9 → req_ready[2]=0 until buf0 is granted, then 1 in the same cycle; pending[9] stays high continuously until the second write leaves rf_*.
- Reset asserted with 3 buffers full and rf_enable=1 → after the edge: rf_enable=0, pending=0, no further writes. Drive commit_count to 0xFFFF, then one more commit → 0x0000.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: NREQ one-entry writeback buffers share a
// single registered write port with round-robin arbitration, in-order
// same-register commits and a pending-write scoreboard for hazard stalls.
module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 16,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_rd,
    input  logic [32*NREQ-1:0]   req_data,
    output logic                 rf_enable,
    output logic [4:0]           rf_RW,
    output logic [31:0]          rf_PW,
    output logic [31:0]          pending,
    output logic [IW-1:0]        grant_id,
    output logic [CW-1:0]        commit_count
);

    // Holding buffers (one entry per requester)
    logic [NREQ-1:0] buf_vld_p0;
    logic [4:0]      buf_rd_p0   [NREQ];
    logic [31:0]     buf_data_p0 [NREQ];
    logic [IW-1:0]   rr_ptr;

    logic            gnt_any;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt_vec;
    logic [NREQ-1:0] rdy;
    logic [NREQ-1:0] accept;
    logic [31:0]     pend;

    // Round-robin grant: first valid buffer scanning upward from rr_ptr
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_any && buf_vld_p0[idx]) begin
                gnt_any      = 1'b1;
                gnt_idx      = IW'(idx);
                gnt_vec[idx] = 1'b1;
            end
        end
    end

    // Ready: buffer free (or draining now), no other live buffer holds the
    // same register, and no lower-index requester takes that register now.
    // Lower indices are resolved first so same-cycle ties go to the lowest.
    always_comb begin
        logic       ok;
        logic [4:0] rd_i;
        ok   = 1'b0;
        rd_i = '0;
        rdy  = '0;
        for (int i = 0; i < NREQ; i++) begin
            rd_i = req_rd[5*i +: 5];
            ok   = reset_n & (~buf_vld_p0[i] | gnt_vec[i]);
            if (rd_i != 5'd0) begin
                for (int j = 0; j < NREQ; j++) begin
                    if (j != i && buf_vld_p0[j] && !gnt_vec[j] && buf_rd_p0[j] == rd_i)
                        ok = 1'b0;
                end
            end
            for (int j = 0; j < i; j++) begin
                if (req_valid[j] && rdy[j] && req_rd[5*j +: 5] == rd_i)
                    ok = 1'b0;
            end
            rdy[i] = ok;
        end
    end

    assign req_ready = rdy;
    assign accept    = req_valid & rdy;

    // Buffer occupancy: load on a nonzero-rd accept, free when granted
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            buf_vld_p0 <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i])
                    buf_vld_p0[i] <= (req_rd[5*i +: 5] != 5'd0);
                else if (gnt_vec[i])
                    buf_vld_p0[i] <= 1'b0;
            end
        end
    end

    // Buffer payload: captured on accept, meaningful only while valid
    always_ff @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i] && req_rd[5*i +: 5] != 5'd0) begin
                buf_rd_p0[i]   <= req_rd[5*i +: 5];
                buf_data_p0[i] <= req_data[32*i +: 32];
            end
        end
    end

    // Write-port stage: register the granted write, advance pointer, count commits
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rf_enable    <= 1'b0;
            rf_RW        <= '0;
            rf_PW        <= '0;
            grant_id     <= '0;
            rr_ptr       <= '0;
            commit_count <= '0;
        end else begin
            rf_enable    <= gnt_any;
            commit_count <= commit_count + CW'(rf_enable);
            if (gnt_any) begin
                rf_RW    <= buf_rd_p0[gnt_idx];
                rf_PW    <= buf_data_p0[gnt_idx];
                grant_id <= gnt_idx;
                rr_ptr   <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            end
        end
    end

    // Scoreboard: registers with a write buffered or on the write port
    always_comb begin
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (buf_vld_p0[i])
                pend[buf_rd_p0[i]] = 1'b1;
        end
        if (rf_enable)
            pend[rf_RW] = 1'b1;
        pend[0] = 1'b0;
    end

    assign pending = pend;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: reset, ready-rule vector table, directed
// multi-cycle sequences, randomized traffic against a behavioural model, and
// commit counter wrap.
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [5*NREQ-1:0] req_rd;
    logic [32*NREQ-1:0] req_data;
    logic              rf_enable;
    logic [4:0]        rf_RW;
    logic [31:0]       rf_PW;
    logic [31:0]       pending;
    logic [1:0]        grant_id;
    logic [CW-1:0]     commit_count;

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .rf_enable    (rf_enable),
        .rf_RW        (rf_RW),
        .rf_PW        (rf_PW),
        .pending      (pending),
        .grant_id     (grant_id),
        .commit_count (commit_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  valid;
        logic [19:0] rd;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_commits;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
        req_valid[i]         = v;
        req_rd[5*i +: 5]     = rd;
        req_data[32*i +: 32] = d;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    function automatic logic [19:0] pack4(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] c, input logic [4:0] d);
        return {d, c, b, a};
    endfunction

    initial begin : main
        vec_t        vt[6];
        int          exp_total;
        int          n;
        // behavioural model state
        bit          mv[NREQ];
        logic [4:0]  mrd[NREQ];
        logic [31:0] mdat[NREQ];
        int          mrr, mgid, gnt, fidx;
        bit          men, ok;
        logic [4:0]  mrw, rdi;
        logic [15:0] mcnt;
        logic [3:0]  erdy;
        logic [31:0] epend;

        vt[0] = '{4'b0001, pack4(5'd1, 5'd2, 5'd3, 5'd4), 4'b1111, 4'd1};
        vt[1] = '{4'b1010, pack4(5'd0, 5'd7, 5'd2, 5'd7), 4'b0111, 4'd1};
        vt[2] = '{4'b1111, pack4(5'd3, 5'd3, 5'd3, 5'd3), 4'b0001, 4'd1};
        vt[3] = '{4'b0000, pack4(5'd3, 5'd3, 5'd3, 5'd3), 4'b1111, 4'd0};
        vt[4] = '{4'b0110, pack4(5'd9, 5'd9, 5'd9, 5'd5), 4'b1011, 4'd1};
        vt[5] = '{4'b1111, pack4(5'd0, 5'd4, 5'd6, 5'd4), 4'b0111, 4'd2};

        // ---- reset state ----
        reset_n   = 1'b0;
        req_valid = '1;
        req_rd    = pack4(5'd1, 5'd2, 5'd3, 5'd4);
        req_data  = '0;
        settle();
        chk("reset_ready", 64'(req_ready), 64'd0);
        step();
        req_valid = '0;
        step();
        reset_n = 1'b1;
        settle();
        chk("reset_en", 64'(rf_enable), 64'd0);
        chk("reset_rw", 64'(rf_RW), 64'd0);
        chk("reset_pw", 64'(rf_PW), 64'd0);
        chk("reset_gid", 64'(grant_id), 64'd0);
        chk("reset_cnt", 64'(commit_count), 64'd0);
        chk("reset_pend", 64'(pending), 64'd0);

        // ---- single write latency ----
        step();
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        settle();
        chk("single_ready", 64'(req_ready[0]), 64'd1);
        step();
        req_valid = '0;
        settle();
        chk("single_en_k", 64'(rf_enable), 64'd0);
        chk("single_pend_k", 64'(pending[5]), 64'd1);
        step();
        settle();
        chk("single_en", 64'(rf_enable), 64'd1);
        chk("single_rw", 64'(rf_RW), 64'd5);
        chk("single_pw", 64'(rf_PW), 64'hDEADBEEF);
        chk("single_pend_k1", 64'(pending[5]), 64'd1);
        step();
        settle();
        chk("single_en_off", 64'(rf_enable), 64'd0);
        chk("single_pend_off", 64'(pending), 64'd0);
        chk("single_cnt", 64'(commit_count), 64'd1);

        // ---- round robin with all requesters saturated ----
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'hC000_0000 + i);
        step();
        for (int k = 0; k < 12; k++) begin
            step();
            settle();
            chk("rr_gid", 64'(grant_id), 64'(k % NREQ));
            chk("rr_en", 64'(rf_enable), 64'd1);
            chk("rr_rw", 64'(rf_RW), 64'((k % NREQ) + 1));
            chk("rr_pw", 64'(rf_PW), 64'(32'hC000_0000 + (k % NREQ)));
        end
        req_valid = '0;

        // ---- same-register contention, lower index first ----
        do_reset();
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b1, 5'd7, 32'h1111_0001);
        set_req(2, 1'b0, 5'd0, 32'h0);
        set_req(3, 1'b1, 5'd7, 32'h3333_0003);
        settle();
        chk("tie_ready1", 64'(req_ready[1]), 64'd1);
        chk("tie_ready3", 64'(req_ready[3]), 64'd0);
        step();
        req_valid[1] = 1'b0;
        settle();
        chk("tie_ready3_late", 64'(req_ready[3]), 64'd1);
        step();
        req_valid = '0;
        settle();
        chk("tie_first_en", 64'(rf_enable), 64'd1);
        chk("tie_first_pw", 64'(rf_PW), 64'h1111_0001);
        step();
        settle();
        chk("tie_second_rw", 64'(rf_RW), 64'd7);
        chk("tie_second_pw", 64'(rf_PW), 64'h3333_0003);

        // ---- write to R0 is dropped ----
        do_reset();
        set_req(2, 1'b1, 5'd0, 32'h12345678);
        settle();
        chk("r0_ready", 64'(req_ready[2]), 64'd1);
        step();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("r0_en", 64'(rf_enable), 64'd0);
            chk("r0_pend", 64'(pending), 64'd0);
            step();
        end
        settle();
        chk("r0_cnt", 64'(commit_count), 64'd0);

        // ---- hazard hold on a buffered register ----
        do_reset();
        set_req(0, 1'b1, 5'd1, 32'h0000_0001);
        step();
        set_req(0, 1'b1, 5'd9, 32'h9000_0000);
        set_req(1, 1'b1, 5'd10, 32'hA000_0001);
        settle();
        chk("haz_refill0", 64'(req_ready[0]), 64'd1);
        chk("haz_ready1", 64'(req_ready[1]), 64'd1);
        step();
        req_valid = '0;
        set_req(2, 1'b1, 5'd9, 32'h9000_0002);
        settle();
        chk("haz_block", 64'(req_ready[2]), 64'd0);
        chk("haz_pend_c", 64'(pending[9]), 64'd1);
        step();
        settle();
        chk("haz_release", 64'(req_ready[2]), 64'd1);
        chk("haz_pend_d", 64'(pending[9]), 64'd1);
        step();
        req_valid = '0;
        settle();
        chk("haz_rw1", 64'(rf_RW), 64'd9);
        chk("haz_pw1", 64'(rf_PW), 64'h9000_0000);
        chk("haz_pend_e", 64'(pending[9]), 64'd1);
        step();
        settle();
        chk("haz_pw2", 64'(rf_PW), 64'h9000_0002);
        chk("haz_pend_f", 64'(pending[9]), 64'd1);
        step();
        settle();
        chk("haz_pend_clear", 64'(pending[9]), 64'd0);

        // ---- reset in the middle of traffic ----
        do_reset();
        set_req(0, 1'b1, 5'd10, 32'h1);
        set_req(1, 1'b1, 5'd11, 32'h2);
        set_req(2, 1'b1, 5'd12, 32'h3);
        step();
        req_valid = '0;
        set_req(0, 1'b1, 5'd13, 32'h4);
        settle();
        chk("mid_refill", 64'(req_ready[0]), 64'd1);
        step();
        req_valid = '0;
        settle();
        chk("mid_en_before", 64'(rf_enable), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_ready_rst", 64'(req_ready), 64'd0);
        step();
        settle();
        chk("mid_en_after", 64'(rf_enable), 64'd0);
        chk("mid_pend_after", 64'(pending), 64'd0);
        chk("mid_cnt_after", 64'(commit_count), 64'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            settle();
            chk("mid_no_write", 64'(rf_enable), 64'd0);
        end
        chk("mid_cnt_idle", 64'(commit_count), 64'd0);

        // ---- ready-rule vector table from empty buffers ----
        do_reset();
        exp_total = 0;
        foreach (vt[v]) begin
            req_valid = vt[v].valid;
            req_rd    = vt[v].rd;
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            settle();
            chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(vt[v].exp_ready));
            step();
            req_valid = '0;
            exp_total += int'(vt[v].exp_commits);
            repeat (6) step();
            settle();
            chk($sformatf("vec%0d_cnt", v), 64'(commit_count), 64'(exp_total));
            step();
        end

        // ---- randomized traffic against the behavioural model ----
        do_reset();
        sb.delete();
        for (int i = 0; i < NREQ; i++) begin
            mv[i] = 1'b0; mrd[i] = '0; mdat[i] = '0;
        end
        mrr = 0; mgid = 0; men = 1'b0; mrw = '0; mcnt = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            settle();
            // model: who is granted and who may be accepted this cycle
            gnt = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (gnt < 0 && mv[(mrr + k) % NREQ]) gnt = (mrr + k) % NREQ;
            end
            erdy = '0;
            for (int i = 0; i < NREQ; i++) begin
                rdi = req_rd[5*i +: 5];
                ok  = !mv[i] || (gnt == i);
                if (rdi != 5'd0) begin
                    for (int j = 0; j < NREQ; j++)
                        if (j != i && j != gnt && mv[j] && mrd[j] == rdi) ok = 1'b0;
                end
                for (int j = 0; j < i; j++)
                    if (req_valid[j] && erdy[j] && req_rd[5*j +: 5] == rdi) ok = 1'b0;
                erdy[i] = ok;
            end
            epend = '0;
            for (int i = 0; i < NREQ; i++) if (mv[i]) epend[mrd[i]] = 1'b1;
            if (men) epend[mrw] = 1'b1;
            epend[0] = 1'b0;
            chk("rnd_ready", 64'(req_ready), 64'(erdy));
            chk("rnd_en", 64'(rf_enable), 64'(men));
            chk("rnd_rw", 64'(rf_RW), 64'(mrw));
            chk("rnd_gid", 64'(grant_id), 64'(mgid));
            chk("rnd_pend", 64'(pending), 64'(epend));
            chk("rnd_cnt", 64'(commit_count), 64'(mcnt));
            // per-register ordering scoreboard
            if (rf_enable) begin
                fidx = -1;
                foreach (sb[s]) if (fidx < 0 && sb[s].rd == rf_RW) fidx = s;
                chk("rnd_sb_found", 64'(fidx >= 0), 64'd1);
                if (fidx >= 0) begin
                    chk("rnd_sb_data", 64'(rf_PW), 64'(sb[fidx].data));
                    sb.delete(fidx);
                end
            end
            step();
            mcnt = mcnt + 16'(men);
            if (gnt >= 0) begin
                men = 1'b1; mrw = mrd[gnt]; mgid = gnt;
                mrr = (gnt + 1) % NREQ; mv[gnt] = 1'b0;
            end else begin
                men = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && erdy[i] && req_rd[5*i +: 5] != 5'd0) begin
                    mv[i] = 1'b1; mrd[i] = req_rd[5*i +: 5]; mdat[i] = req_data[32*i +: 32];
                    sb.push_back('{rd: mrd[i], data: mdat[i]});
                end
            end
        end
        req_valid = '0;

        // ---- commit counter wrap ----
        do_reset();
        set_req(0, 1'b1, 5'd1, 32'h5555_AAAA);
        n = 0;
        settle();
        while (commit_count != 16'hFFFF && n < 70000) begin
            step();
            settle();
            n++;
        end
        chk("wrap_reach", 64'(commit_count), 64'hFFFF);
        chk("wrap_en", 64'(rf_enable), 64'd1);
        step();
        req_valid = '0;
        settle();
        chk("wrap_zero", 64'(commit_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
